// File: rtl/icache_param.sv
// icache_param: set-associative instruction cache between a CPU fetch stage
// and a memory read channel. Read path only. Victims are chosen invalid-first,
// then per-set round-robin. Addresses with (addr & IO_MASK) != 0 bypass the
// cache with a single-beat read. inv_req sweeps all valid bits, one set per
// cycle, and reset enters that same sweep.
//
// Ports:
//   clk, rst (sync, active-low)
//   from_cpu_inst_req_valid/addr, to_cpu_inst_req_ready  : fetch request
//   to_cpu_cache_rsp_valid/data, from_cpu_cache_rsp_ready : fetch response
//   inv_req, inv_busy                                     : whole-cache invalidate
//   to_mem_rd_req_valid/addr/len, from_mem_rd_req_ready   : read burst request
//   from_mem_rd_rsp_valid/data/last, to_mem_rd_rsp_ready  : read burst beats
//   fsm_state                                             : current FSM state
//
// Handshakes: every channel transfers on a rising edge where valid and ready
// are both high; a valid source holds its payload stable until that edge.
module icache_param #(
  parameter int          NUM_WAY    = 4,
  parameter int          NUM_SET    = 16,
  parameter int          LINE_WORDS = 8,
  parameter logic [31:0] IO_MASK    = 32'hc000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        from_cpu_inst_req_valid,
  input  logic [31:0] from_cpu_inst_req_addr,
  output logic        to_cpu_inst_req_ready,
  output logic        to_cpu_cache_rsp_valid,
  output logic [31:0] to_cpu_cache_rsp_data,
  input  logic        from_cpu_cache_rsp_ready,
  input  logic        inv_req,
  output logic        inv_busy,
  output logic        to_mem_rd_req_valid,
  output logic [31:0] to_mem_rd_req_addr,
  output logic [7:0]  to_mem_rd_req_len,
  input  logic        from_mem_rd_req_ready,
  input  logic        from_mem_rd_rsp_valid,
  input  logic [31:0] from_mem_rd_rsp_data,
  input  logic        from_mem_rd_rsp_last,
  output logic        to_mem_rd_rsp_ready,
  output logic [2:0]  fsm_state
);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(NUM_SET);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WAY_W  = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_BP_REQ, S_BP_WAIT, S_RESP, S_INV
  } state_t;

  state_t state;

  logic [31:0]       data_mem [NUM_WAY][NUM_SET][LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [NUM_WAY][NUM_SET];
  logic [NUM_WAY-1:0] valid_q [NUM_SET];
  logic [WAY_W-1:0]  rr_q     [NUM_SET];
  logic [31:0]       line_buf [LINE_WORDS];

  logic [31:2]       req_addr;
  logic              ready_q;
  logic              hit_q;
  logic [WORD_W-1:0] beat_cnt;
  logic [IDX_W-1:0]  inv_cnt;

  logic [IDX_W-1:0]  in_idx, req_idx;
  logic [TAG_W-1:0]  in_tag, req_tag;
  logic [WORD_W-1:0] in_word, req_word;
  logic              in_io, accept, lk_hit, has_inv, fill_en;
  logic [31:0]       lk_data;
  logic [WAY_W-1:0]  vic_way;

  assign in_idx   = from_cpu_inst_req_addr[OFF_W+IDX_W-1:OFF_W];
  assign in_tag   = from_cpu_inst_req_addr[31:OFF_W+IDX_W];
  assign in_word  = from_cpu_inst_req_addr[OFF_W-1:2];
  assign req_idx  = req_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag  = req_addr[31:OFF_W+IDX_W];
  assign req_word = req_addr[OFF_W-1:2];
  assign in_io    = (from_cpu_inst_req_addr & IO_MASK) != 32'h0;

  // An invalidate request in the same cycle takes priority over a fetch.
  assign to_cpu_inst_req_ready = ready_q & ~inv_req;
  assign accept    = from_cpu_inst_req_valid & to_cpu_inst_req_ready;
  assign fill_en   = rst && (state == S_REFILL) && from_mem_rd_rsp_valid && from_mem_rd_rsp_last;
  assign fsm_state = state;

  // Tag compare runs on the incoming address so the hit response can be
  // registered at the accept edge and appear in the very next cycle.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int w = 0; w < NUM_WAY; w++) begin
      if (valid_q[in_idx][w] && (tag_mem[w][in_idx] == in_tag)) begin
        lk_hit  = 1'b1;
        lk_data = data_mem[w][in_idx][in_word];
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    vic_way = rr_q[req_idx];
    has_inv = 1'b0;
    for (int w = NUM_WAY - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        vic_way = WAY_W'(w);
        has_inv = 1'b1;
      end
    end
  end

  // Line storage: the whole line (buffered beats plus the final beat) is
  // written at once, so an aborted burst never leaves a partial line.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        data_mem[vic_way][req_idx][i] <= (WORD_W'(i) == beat_cnt) ? from_mem_rd_rsp_data : line_buf[i];
      end
      tag_mem[vic_way][req_idx] <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                  <= S_INV;
      inv_cnt                <= '0;
      ready_q                <= 1'b0;
      hit_q                  <= 1'b0;
      beat_cnt               <= '0;
      req_addr               <= '0;
      to_cpu_cache_rsp_valid <= 1'b0;
      to_cpu_cache_rsp_data  <= '0;
      to_mem_rd_req_valid    <= 1'b0;
      to_mem_rd_req_addr     <= '0;
      to_mem_rd_req_len      <= '0;
      to_mem_rd_rsp_ready    <= 1'b0;
      inv_busy               <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (inv_req) begin
            state    <= S_INV;
            inv_cnt  <= '0;
            inv_busy <= 1'b1;
            ready_q  <= 1'b0;
          end else if (accept) begin
            req_addr <= from_cpu_inst_req_addr[31:2];
            ready_q  <= 1'b0;
            if (in_io) begin
              state               <= S_BP_REQ;
              to_mem_rd_req_valid <= 1'b1;
              to_mem_rd_req_addr  <= {from_cpu_inst_req_addr[31:2], 2'b00};
              to_mem_rd_req_len   <= 8'd0;
            end else begin
              state                  <= S_LOOKUP;
              hit_q                  <= lk_hit;
              to_cpu_cache_rsp_valid <= lk_hit;
              if (lk_hit) to_cpu_cache_rsp_data <= lk_data;
            end
          end
        end
        S_LOOKUP: begin
          if (hit_q) begin
            if (from_cpu_cache_rsp_ready) begin
              to_cpu_cache_rsp_valid <= 1'b0;
              ready_q                <= 1'b1;
              state                  <= S_IDLE;
            end
          end else begin
            state               <= S_MISS_REQ;
            to_mem_rd_req_valid <= 1'b1;
            to_mem_rd_req_addr  <= {req_addr[31:OFF_W], {OFF_W{1'b0}}};
            to_mem_rd_req_len   <= 8'(LINE_WORDS - 1);
          end
        end
        S_MISS_REQ: begin
          if (from_mem_rd_req_ready) begin
            to_mem_rd_req_valid <= 1'b0;
            to_mem_rd_rsp_ready <= 1'b1;
            beat_cnt            <= '0;
            state               <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (from_mem_rd_rsp_valid) begin
            line_buf[beat_cnt] <= from_mem_rd_rsp_data;
            beat_cnt           <= beat_cnt + 1'b1;
            if (from_mem_rd_rsp_last) begin
              to_mem_rd_rsp_ready    <= 1'b0;
              to_cpu_cache_rsp_valid <= 1'b1;
              // The requested word may be the one arriving on this beat.
              to_cpu_cache_rsp_data  <= (req_word == beat_cnt) ? from_mem_rd_rsp_data : line_buf[req_word];
              valid_q[req_idx][vic_way] <= 1'b1;
              if (!has_inv) begin
                rr_q[req_idx] <= (rr_q[req_idx] == WAY_W'(NUM_WAY - 1)) ? '0 : rr_q[req_idx] + 1'b1;
              end
              state <= S_RESP;
            end
          end
        end
        S_BP_REQ: begin
          if (from_mem_rd_req_ready) begin
            to_mem_rd_req_valid <= 1'b0;
            to_mem_rd_rsp_ready <= 1'b1;
            state               <= S_BP_WAIT;
          end
        end
        S_BP_WAIT: begin
          if (from_mem_rd_rsp_valid && from_mem_rd_rsp_last) begin
            to_mem_rd_rsp_ready    <= 1'b0;
            to_cpu_cache_rsp_valid <= 1'b1;
            to_cpu_cache_rsp_data  <= from_mem_rd_rsp_data;
            state                  <= S_RESP;
          end
        end
        S_RESP: begin
          if (from_cpu_cache_rsp_ready) begin
            to_cpu_cache_rsp_valid <= 1'b0;
            ready_q                <= 1'b1;
            state                  <= S_IDLE;
          end
        end
        S_INV: begin
          valid_q[inv_cnt] <= '0;
          rr_q[inv_cnt]    <= '0;
          inv_cnt          <= inv_cnt + 1'b1;
          if (inv_cnt == IDX_W'(NUM_SET - 1)) begin
            inv_busy <= 1'b0;
            ready_q  <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_INV;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_param.sv
// Directed bench for icache_param (default parameters): a table of fetches
// with hand-computed data and memory-request expectations, followed by
// hand-written invalidate and mid-refill-reset sequences.
module tb_icache_param;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        from_cpu_inst_req_valid;
  logic [31:0] from_cpu_inst_req_addr;
  logic        to_cpu_inst_req_ready;
  logic        to_cpu_cache_rsp_valid;
  logic [31:0] to_cpu_cache_rsp_data;
  logic        from_cpu_cache_rsp_ready;
  logic        inv_req;
  logic        inv_busy;
  logic        to_mem_rd_req_valid;
  logic [31:0] to_mem_rd_req_addr;
  logic [7:0]  to_mem_rd_req_len;
  logic        from_mem_rd_req_ready;
  logic        from_mem_rd_rsp_valid;
  logic [31:0] from_mem_rd_rsp_data;
  logic        from_mem_rd_rsp_last;
  logic        to_mem_rd_rsp_ready;
  logic [2:0]  fsm_state;

  icache_param dut (
    .clk                      (clk),
    .rst                      (rst_n),
    .from_cpu_inst_req_valid  (from_cpu_inst_req_valid),
    .from_cpu_inst_req_addr   (from_cpu_inst_req_addr),
    .to_cpu_inst_req_ready    (to_cpu_inst_req_ready),
    .to_cpu_cache_rsp_valid   (to_cpu_cache_rsp_valid),
    .to_cpu_cache_rsp_data    (to_cpu_cache_rsp_data),
    .from_cpu_cache_rsp_ready (from_cpu_cache_rsp_ready),
    .inv_req                  (inv_req),
    .inv_busy                 (inv_busy),
    .to_mem_rd_req_valid      (to_mem_rd_req_valid),
    .to_mem_rd_req_addr       (to_mem_rd_req_addr),
    .to_mem_rd_req_len        (to_mem_rd_req_len),
    .from_mem_rd_req_ready    (from_mem_rd_req_ready),
    .from_mem_rd_rsp_valid    (from_mem_rd_rsp_valid),
    .from_mem_rd_rsp_data     (from_mem_rd_rsp_data),
    .from_mem_rd_rsp_last     (from_mem_rd_rsp_last),
    .to_mem_rd_rsp_ready      (to_mem_rd_rsp_ready),
    .fsm_state                (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  int          rsp_cnt = 0;
  int          req_cnt = 0;
  int          req_cyc = 0;
  int          last_cyc = 0;
  int          beat_idx = -1;
  int          bad_traffic = 0;
  logic [31:0] last_req_addr;
  logic [7:0]  last_req_len;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    int          kind;        // 0 hit, 1 line miss, 2 uncached bypass
    logic [31:0] exp_req_addr;
    logic [7:0]  exp_len;
    int          hold;        // cycles of response back-pressure
  } vec_t;

  localparam int N_VEC = 18;
  vec_t vecs [N_VEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image seen by the responder.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if ((a & 32'hC000_0000) != 32'h0) return 32'hDEAD_BEEF;
    return 32'h0000_0FC0 + (a >> 2);
  endfunction

  // ---------------- scoreboard / monitors ----------------
  always @(negedge clk) begin
    if (rst_n && to_cpu_cache_rsp_valid && from_cpu_cache_rsp_ready) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_rsp: got %h expected none", to_cpu_cache_rsp_data);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_rsp_data", to_cpu_cache_rsp_data, sb_exp);
      end
    end
    if (to_mem_rd_req_valid && (inv_busy || !rst_n)) bad_traffic++;
  end

  // ---------------- memory responder ----------------
  // Accepts one request at a time; inserts an invalid beat (with last set and
  // junk data) before beat 2 of every multi-beat burst. Aborts on reset.
  initial begin
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic        acc;
    logic        abort;
    int          t;
    from_mem_rd_req_ready = 1'b0;
    from_mem_rd_rsp_valid = 1'b0;
    from_mem_rd_rsp_data  = '0;
    from_mem_rd_rsp_last  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && to_mem_rd_req_valid) begin
        m_addr = to_mem_rd_req_addr;
        m_len  = to_mem_rd_req_len;
        req_cnt++;
        last_req_addr = m_addr;
        last_req_len  = m_len;
        req_cyc = cyc;
        from_mem_rd_req_ready = 1'b1;
        @(posedge clk); #1;
        from_mem_rd_req_ready = 1'b0;
        abort = 1'b0;
        for (int k = 0; k <= int'(m_len) && !abort; k++) begin
          if (k == 2) begin
            from_mem_rd_rsp_valid = 1'b0;
            from_mem_rd_rsp_data  = 32'hBAD0_BAD0;
            from_mem_rd_rsp_last  = 1'b1;
            @(posedge clk); #1;
          end
          beat_idx = k;
          from_mem_rd_rsp_valid = 1'b1;
          from_mem_rd_rsp_data  = mem_word(m_addr + 32'(4 * k));
          from_mem_rd_rsp_last  = (k == int'(m_len));
          t = 0;
          forever begin
            @(negedge clk);
            acc = to_mem_rd_rsp_ready;
            @(posedge clk); #1;
            if (!rst_n) begin abort = 1'b1; break; end
            if (acc) break;
            t++;
            if (t > 100) begin abort = 1'b1; break; end
          end
        end
        from_mem_rd_rsp_valid = 1'b0;
        from_mem_rd_rsp_last  = 1'b0;
        beat_idx = -1;
        if (!abort) last_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] addr, output int hs_cyc);
    logic hs;
    int   t;
    from_cpu_inst_req_valid = 1'b1;
    from_cpu_inst_req_addr  = addr;
    t = 0;
    forever begin
      @(negedge clk);
      hs = to_cpu_inst_req_ready;
      @(posedge clk); #1;
      if (hs) break;
      t++;
      if (t > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL req_handshake_timeout: got no ready expected ready for %h", addr);
        break;
      end
    end
    hs_cyc = cyc;
    from_cpu_inst_req_valid = 1'b0;
  endtask

  task automatic fetch(input vec_t v);
    int          req0, rsp0, hs_cyc, seen_cyc, t;
    logic [31:0] d0;
    req0 = req_cnt;
    rsp0 = rsp_cnt;
    exp_q.push_back(v.exp_data);
    issue(v.addr, hs_cyc);
    if (v.kind == 0) check("hit_rsp_next_cycle", 32'(to_cpu_cache_rsp_valid), 32'd1);
    else             check("miss_no_early_rsp", 32'(to_cpu_cache_rsp_valid), 32'd0);
    t = 0;
    while (!to_cpu_cache_rsp_valid && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    seen_cyc = cyc;
    if (!to_cpu_cache_rsp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got no response expected %h for %h", v.exp_data, v.addr);
      void'(exp_q.pop_back());
      return;
    end
    d0 = to_cpu_cache_rsp_data;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      check("bp_valid_held", 32'(to_cpu_cache_rsp_valid), 32'd1);
      check("bp_data_stable", to_cpu_cache_rsp_data, d0);
    end
    from_cpu_cache_rsp_ready = 1'b1;
    @(posedge clk); #1;
    from_cpu_cache_rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(to_cpu_cache_rsp_valid), 32'd0);
    check("rsp_count", 32'(rsp_cnt - rsp0), 32'd1);
    check("mem_req_count", 32'(req_cnt - req0), (v.kind == 0) ? 32'd0 : 32'd1);
    if (v.kind != 0) begin
      check("mem_req_addr", last_req_addr, v.exp_req_addr);
      check("mem_req_len", 32'(last_req_len), 32'(v.exp_len));
      check("mem_req_latency", 32'(req_cyc - hs_cyc), (v.kind == 2) ? 32'd0 : 32'd1);
      check("rsp_after_last", 32'(seen_cyc - last_cyc), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   n, bad, hs_cyc;
    vec_t v;
    rst_n = 1'b0;
    inv_req = 1'b0;
    from_cpu_inst_req_valid = 1'b0;
    from_cpu_inst_req_addr  = '0;
    from_cpu_cache_rsp_ready = 1'b0;

    vecs[0]  = '{32'h0000_0100, 32'h0000_1000, 1, 32'h0000_0100, 8'd7, 0};
    vecs[1]  = '{32'h0000_0104, 32'h0000_1001, 0, 32'h0, 8'd0, 0};
    vecs[2]  = '{32'h0000_011C, 32'h0000_1007, 0, 32'h0, 8'd0, 0};
    vecs[3]  = '{32'h0000_0000, 32'h0000_0FC0, 1, 32'h0000_0000, 8'd7, 0};
    vecs[4]  = '{32'h0000_0200, 32'h0000_1040, 1, 32'h0000_0200, 8'd7, 0};
    vecs[5]  = '{32'h0000_0400, 32'h0000_10C0, 1, 32'h0000_0400, 8'd7, 0};
    vecs[6]  = '{32'h0000_0600, 32'h0000_1140, 1, 32'h0000_0600, 8'd7, 0};
    vecs[7]  = '{32'h0000_0004, 32'h0000_0FC1, 0, 32'h0, 8'd0, 0};
    vecs[8]  = '{32'h0000_0800, 32'h0000_11C0, 1, 32'h0000_0800, 8'd7, 0};
    vecs[9]  = '{32'h0000_0204, 32'h0000_1041, 0, 32'h0, 8'd0, 0};
    vecs[10] = '{32'h0000_0008, 32'h0000_0FC2, 1, 32'h0000_0000, 8'd7, 0};
    vecs[11] = '{32'h0000_0404, 32'h0000_10C1, 0, 32'h0, 8'd0, 0};
    vecs[12] = '{32'h0000_0208, 32'h0000_1042, 1, 32'h0000_0200, 8'd7, 0};
    vecs[13] = '{32'hC000_0010, 32'hDEAD_BEEF, 2, 32'hC000_0010, 8'd0, 0};
    vecs[14] = '{32'hC000_0010, 32'hDEAD_BEEF, 2, 32'hC000_0010, 8'd0, 0};
    vecs[15] = '{32'h0000_010C, 32'h0000_1003, 0, 32'h0, 8'd0, 5};
    vecs[16] = '{32'h0000_080C, 32'h0000_11C3, 0, 32'h0, 8'd0, 0};
    vecs[17] = '{32'h0000_040C, 32'h0000_10C3, 1, 32'h0000_0400, 8'd7, 0};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(to_cpu_inst_req_ready), 32'd0);
    check("rst_rsp_valid", 32'(to_cpu_cache_rsp_valid), 32'd0);
    check("rst_rsp_data", to_cpu_cache_rsp_data, 32'd0);
    check("rst_rd_req_valid", 32'(to_mem_rd_req_valid), 32'd0);
    check("rst_rd_req_addr", to_mem_rd_req_addr, 32'd0);
    check("rst_rd_req_len", 32'(to_mem_rd_req_len), 32'd0);
    check("rst_rd_rsp_ready", 32'(to_mem_rd_rsp_ready), 32'd0);
    check("rst_inv_busy", 32'(inv_busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!to_cpu_inst_req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reset_sweep_cycles", 32'(n), 32'd16);
    check("reset_sweep_busy_drop", 32'(inv_busy), 32'd0);

    // Table of fetches.
    for (int i = 0; i < N_VEC; i++) fetch(vecs[i]);

    // Invalidate wins over a simultaneous fetch; sweep lasts 16 cycles.
    inv_req = 1'b1;
    from_cpu_inst_req_valid = 1'b1;
    from_cpu_inst_req_addr  = 32'h0000_0100;
    @(negedge clk);
    check("inv_forces_ready_low", 32'(to_cpu_inst_req_ready), 32'd0);
    @(posedge clk); #1;
    inv_req = 1'b0;
    from_cpu_inst_req_valid = 1'b0;
    n = 0;
    bad = 0;
    while (inv_busy && n < 100) begin
      if (to_cpu_inst_req_ready) bad++;
      n++;
      @(posedge clk); #1;
    end
    check("inv_busy_cycles", 32'(n), 32'd16);
    check("inv_ready_low", 32'(bad), 32'd0);
    check("inv_no_rsp", 32'(to_cpu_cache_rsp_valid), 32'd0);
    v = '{32'h0000_0104, 32'h0000_1001, 1, 32'h0000_0100, 8'd7, 0};
    fetch(v);

    // Reset while beat 3 of a refill is on the bus.
    issue(32'h0000_00A0, hs_cyc);
    n = 0;
    while (beat_idx != 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("refill_reached_beat3", 32'(beat_idx), 32'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_rd_rsp_ready", 32'(to_mem_rd_rsp_ready), 32'd0);
    check("abort_inv_busy", 32'(inv_busy), 32'd1);
    check("abort_no_rsp", 32'(to_cpu_cache_rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!to_cpu_inst_req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_sweep_cycles", 32'(n), 32'd16);
    v = '{32'h0000_00A0, 32'h0000_0FE8, 1, 32'h0000_00A0, 8'd7, 0};
    fetch(v);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("no_traffic_in_inv_or_reset", 32'(bad_traffic), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
